// File: rtl/bsg_cell_rr_arbiter_if.sv
// rtl/bsg_cell_rr_arbiter_if.sv - requester, cell and response bundle for the rr cell arbiter
interface bsg_cell_rr_arbiter_if #(
    parameter int num_req_p = 4,
    parameter int width_p   = 10
);
    logic [num_req_p-1:0]         req_v_i;
    logic [num_req_p*width_p-1:0] req_data_i;
    logic [num_req_p-1:0]         req_ready_o;
    logic                         cell_v_o;
    logic [width_p-1:0]           cell_data_o;
    logic                         cell_ready_i;
    logic                         cell_v_i;
    logic [width_p-1:0]           cell_data_i;
    logic                         cell_yumi_o;
    logic [num_req_p-1:0]         resp_v_o;
    logic [width_p-1:0]           resp_data_o;
    logic [num_req_p-1:0]         resp_yumi_i;
    logic                         error_o;

    modport master (
        output req_v_i, req_data_i, cell_ready_i, cell_v_i, cell_data_i, resp_yumi_i,
        input  req_ready_o, cell_v_o, cell_data_o, cell_yumi_o, resp_v_o, resp_data_o, error_o
    );

    modport slave (
        input  req_v_i, req_data_i, cell_ready_i, cell_v_i, cell_data_i, resp_yumi_i,
        output req_ready_o, cell_v_o, cell_data_o, cell_yumi_o, resp_v_o, resp_data_o, error_o
    );
endinterface

// File: rtl/bsg_cell_rr_arbiter.sv
// rtl/bsg_cell_rr_arbiter.sv - round-robin arbiter sharing one cell, tag FIFO routes responses back
module bsg_cell_rr_arbiter #(
    parameter int num_req_p = 4,
    parameter int width_p   = 10,
    parameter int tag_els_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_cell_rr_arbiter_if.slave io
);
    localparam int lg_req = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int lg_tag = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
    localparam int cnt_w  = $clog2(tag_els_p + 1);

    logic [lg_req-1:0] r_rr;
    logic              r_lock;
    logic [lg_req-1:0] r_locked_id;
    logic [lg_req-1:0] r_tags [tag_els_p];
    logic [lg_tag-1:0] r_wptr;
    logic [lg_tag-1:0] r_rptr;
    logic [cnt_w-1:0]  r_count;
    logic              r_error;

    logic [lg_req-1:0] w_cand;
    logic              w_cand_v;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic              w_yumi;
    logic              w_resp_v;
    logic [lg_req-1:0] w_head;
    int                w_idx;

    function automatic logic [lg_tag-1:0] f_tag_inc(input logic [lg_tag-1:0] p);
        return (p == lg_tag'(tag_els_p - 1)) ? '0 : p + lg_tag'(1);
    endfunction

    // A held lock pins the grant; a dropped locked request yields no candidate until the lock clears.
    always_comb begin
        w_cand   = '0;
        w_cand_v = 1'b0;
        w_idx    = 0;
        if (r_lock) begin
            w_cand   = r_locked_id;
            w_cand_v = io.req_v_i[r_locked_id];
        end else begin
            for (int i = num_req_p - 1; i >= 0; i--) begin
                w_idx = (int'(r_rr) + i) % num_req_p;
                if (io.req_v_i[w_idx]) begin
                    w_cand   = lg_req'(w_idx);
                    w_cand_v = 1'b1;
                end
            end
        end
    end

    assign w_full   = (r_count == cnt_w'(tag_els_p));
    assign w_empty  = (r_count == '0);
    assign w_issue  = io.cell_v_o & io.cell_ready_i;
    assign w_head   = r_tags[r_rptr];
    assign w_resp_v = io.cell_v_i & ~w_empty;
    assign w_yumi   = w_resp_v & io.resp_yumi_i[w_head];

    assign io.cell_v_o    = w_cand_v & ~w_full;
    assign io.cell_data_o = io.req_data_i[w_cand*width_p +: width_p];
    assign io.req_ready_o = w_issue ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_cand) : '0;
    assign io.resp_v_o    = w_resp_v ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_head) : '0;
    assign io.resp_data_o = io.cell_data_i;
    assign io.cell_yumi_o = w_yumi;
    assign io.error_o     = r_error;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr        <= '0;
            r_lock      <= 1'b0;
            r_locked_id <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rr   <= (w_cand == lg_req'(num_req_p - 1)) ? '0 : w_cand + lg_req'(1);
                r_lock <= 1'b0;
                r_wptr <= f_tag_inc(r_wptr);
            end else if (io.cell_v_o) begin
                r_lock      <= 1'b1;
                r_locked_id <= w_cand;
            end else if (r_lock && !io.req_v_i[r_locked_id]) begin
                r_lock <= 1'b0;
            end
            if (w_yumi) begin
                r_rptr <= f_tag_inc(r_rptr);
            end
            case ({w_issue, w_yumi})
                2'b10:   r_count <= r_count + cnt_w'(1);
                2'b01:   r_count <= r_count - cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (io.cell_v_i && w_empty) begin
                r_error <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_tags[r_wptr] <= w_cand;
        end
    end
endmodule

// File: tb/tb_bsg_cell_rr_arbiter.sv
// tb/tb_bsg_cell_rr_arbiter.sv - directed self-checking bench for bsg_cell_rr_arbiter
module tb_bsg_cell_rr_arbiter;
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    logic [9:0] dv [4];

    bsg_cell_rr_arbiter_if #(.num_req_p(4), .width_p(10)) bus ();

    bsg_cell_rr_arbiter #(.num_req_p(4), .width_p(10), .tag_els_p(4)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .io        (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.req_v_i      = '0;
        bus.cell_ready_i = 1'b0;
        bus.cell_v_i     = 1'b0;
        bus.cell_data_i  = '0;
        bus.resp_yumi_i  = '0;
    endtask

    initial begin
        dv[0] = 10'h10; dv[1] = 10'h21; dv[2] = 10'h32; dv[3] = 10'h43;
        bus.req_data_i = {dv[3], dv[2], dv[1], dv[0]};
        idle();
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_cell_v", 32'(bus.cell_v_o), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_resp_v", 32'(bus.resp_v_o), 32'd0);
        chk("rst_cell_yumi", 32'(bus.cell_yumi_o), 32'd0);
        chk("rst_error", 32'(bus.error_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // fairness: all valid, cell ready, each response consumed the cycle after its issue
        bus.req_v_i = 4'b1111;
        bus.cell_ready_i = 1'b1;
        bus.resp_yumi_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            bus.cell_v_i = (k > 0);
            #1;
            chk("rr_data", 32'(bus.cell_data_o), 32'(dv[k % 4]));
            chk("rr_ready", 32'(bus.req_ready_o), 32'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("rr_resp_v", 32'(bus.resp_v_o), 32'(4'b0001 << (k - 1)));
                chk("rr_yumi", 32'(bus.cell_yumi_o), 32'd1);
            end
            step();
        end
        bus.req_v_i = 4'b0000;
        bus.cell_v_i = 1'b1;
        #1;
        chk("rr_last_resp", 32'(bus.resp_v_o), 32'b0001);
        chk("rr_last_yumi", 32'(bus.cell_yumi_o), 32'd1);
        chk("rr_idle_cell_v", 32'(bus.cell_v_o), 32'd0);
        step();
        idle();
        #1;
        chk("rr_error", 32'(bus.error_o), 32'd0);
        step();

        // lock: pointer is 1, requester 2 held off by the cell
        bus.req_v_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lock_v", 32'(bus.cell_v_o), 32'd1);
            chk("lock_data", 32'(bus.cell_data_o), 32'h32);
            chk("lock_ready", 32'(bus.req_ready_o), 32'd0);
            step();
        end
        bus.req_v_i = 4'b0111;
        #1;
        chk("lock_hold_data", 32'(bus.cell_data_o), 32'h32);
        step();
        bus.cell_ready_i = 1'b1;
        #1;
        chk("lock_issue_ready", 32'(bus.req_ready_o), 32'b0100);
        chk("lock_issue_data", 32'(bus.cell_data_o), 32'h32);
        step();
        #1;
        chk("lock_next_ready", 32'(bus.req_ready_o), 32'b0001);
        chk("lock_next_data", 32'(bus.cell_data_o), 32'h10);
        step();
        idle();
        bus.cell_v_i = 1'b1;
        bus.resp_yumi_i = 4'b1111;
        #1;
        chk("lock_drain0", 32'(bus.resp_v_o), 32'b0100);
        step();
        #1;
        chk("lock_drain1", 32'(bus.resp_v_o), 32'b0001);
        step();

        // FIFO full: four issues from requester 1, fifth blocked
        idle();
        bus.req_v_i = 4'b0010;
        bus.cell_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_ready", 32'(bus.req_ready_o), 32'b0010);
            step();
        end
        #1;
        chk("full_cell_v", 32'(bus.cell_v_o), 32'd0);
        chk("full_ready", 32'(bus.req_ready_o), 32'd0);
        bus.cell_v_i = 1'b1;
        bus.resp_yumi_i = 4'b0010;
        #1;
        chk("full_pop_resp", 32'(bus.resp_v_o), 32'b0010);
        chk("full_pop_yumi", 32'(bus.cell_yumi_o), 32'd1);
        chk("full_pop_blocked", 32'(bus.cell_v_o), 32'd0);
        step();
        bus.cell_v_i = 1'b0;
        #1;
        chk("full_resume", 32'(bus.req_ready_o), 32'b0010);
        step();
        bus.req_v_i = 4'b0000;
        bus.cell_v_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_drain", 32'(bus.cell_yumi_o), 32'd1);
            step();
        end

        // response routing: issue order 3,0,3 from pointer 2
        idle();
        bus.cell_ready_i = 1'b1;
        bus.req_v_i = 4'b1000;
        #1;
        chk("route_iss3a", 32'(bus.req_ready_o), 32'b1000);
        step();
        bus.req_v_i = 4'b0001;
        #1;
        chk("route_iss0", 32'(bus.req_ready_o), 32'b0001);
        step();
        bus.req_v_i = 4'b1000;
        #1;
        chk("route_iss3b", 32'(bus.req_ready_o), 32'b1000);
        step();
        idle();
        bus.cell_v_i = 1'b1;
        bus.cell_data_i = 10'h2AA;
        bus.resp_yumi_i = 4'b0001;
        #1;
        chk("route_r0_v", 32'(bus.resp_v_o), 32'b1000);
        chk("route_r0_wrong_yumi", 32'(bus.cell_yumi_o), 32'd0);
        chk("route_r0_data", 32'(bus.resp_data_o), 32'h2AA);
        step();
        bus.resp_yumi_i = 4'b1000;
        #1;
        chk("route_r0_yumi", 32'(bus.cell_yumi_o), 32'd1);
        step();
        bus.cell_data_i = 10'h155;
        bus.resp_yumi_i = 4'b0001;
        #1;
        chk("route_r1_v", 32'(bus.resp_v_o), 32'b0001);
        chk("route_r1_yumi", 32'(bus.cell_yumi_o), 32'd1);
        step();
        bus.cell_data_i = 10'h3FF;
        bus.resp_yumi_i = 4'b1000;
        #1;
        chk("route_r2_v", 32'(bus.resp_v_o), 32'b1000);
        chk("route_r2_data", 32'(bus.resp_data_o), 32'h3FF);
        chk("route_r2_yumi", 32'(bus.cell_yumi_o), 32'd1);
        step();

        // orphan response right after reset
        idle();
        reset_n_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        bus.cell_v_i = 1'b1;
        #1;
        chk("orph_resp_v", 32'(bus.resp_v_o), 32'd0);
        chk("orph_yumi", 32'(bus.cell_yumi_o), 32'd0);
        chk("orph_err_pre", 32'(bus.error_o), 32'd0);
        step();
        #1;
        chk("orph_err", 32'(bus.error_o), 32'd1);
        bus.cell_v_i = 1'b0;
        step();
        #1;
        chk("orph_err_sticky", 32'(bus.error_o), 32'd1);

        // reset with two tags outstanding
        bus.req_v_i = 4'b0011;
        bus.cell_ready_i = 1'b1;
        #1;
        chk("mid_iss0", 32'(bus.req_ready_o), 32'b0001);
        step();
        #1;
        chk("mid_iss1", 32'(bus.req_ready_o), 32'b0010);
        step();
        idle();
        bus.cell_v_i = 1'b1;
        #1;
        chk("mid_outstanding", 32'(bus.resp_v_o), 32'b0001);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_err", 32'(bus.error_o), 32'd0);
        chk("mid_rst_resp", 32'(bus.resp_v_o), 32'd0);
        chk("mid_rst_yumi", 32'(bus.cell_yumi_o), 32'd0);
        bus.req_v_i = 4'b1010;
        #1;
        chk("mid_rst_ptr", 32'(bus.cell_data_o), 32'h21);
        chk("mid_rst_cell_v", 32'(bus.cell_v_o), 32'd1);
        idle();
        step();
        reset_n_i = 1'b1;
        bus.req_v_i = 4'b1000;
        bus.cell_ready_i = 1'b1;
        #1;
        chk("post_iss3", 32'(bus.req_ready_o), 32'b1000);
        step();
        idle();
        bus.cell_v_i = 1'b1;
        bus.cell_data_i = 10'h0AB;
        bus.resp_yumi_i = 4'b1000;
        #1;
        chk("post_resp_v", 32'(bus.resp_v_o), 32'b1000);
        chk("post_resp_data", 32'(bus.resp_data_o), 32'h0AB);
        chk("post_yumi", 32'(bus.cell_yumi_o), 32'd1);
        step();
        idle();
        #1;
        chk("post_err", 32'(bus.error_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
